// File: rtl/tc_serial_pkg.sv
// Shared types and constants for the TC serial link blocks.
package tc_serial_pkg;

  localparam int TC_WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width able to hold frame_len-1 down to zero, with one spare code.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry valid/ready holding register that lets the next word wait while
// the current frame shifts out.
module piso_hold_buf
  import tc_serial_pkg::*;
#(
  parameter int DATA_W = TC_WORD_W
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output logic              ready
);

  assign ready = !full;

  // A write alongside a read keeps the entry occupied with the new word.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload register is deliberately left without reset; full alone qualifies it.
  always_ff @(posedge clk_out) begin
    if (wr_en) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and serial framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_stream_serializer
  import tc_serial_pkg::*;
#(
  parameter int DATA_W     = TC_WORD_W,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_first,
  output logic              dout_last,
  output logic              busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int              CNT_W   = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FRAME_LEN - 1);

  state_e              state;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    bitcnt;
  logic [DATA_W-1:0]   hold_data;
  logic                hold_full;
  logic                hold_ready;

  logic                shifting;
  logic                last_bit;
  logic                accept;
  logic                hold_wr;
  logic                hold_rd;
  logic                load_en;
  logic [DATA_W-1:0]   load_word;
  logic                data_bit;
  logic                ser_bit;

  assign shifting  = (state == ST_SHIFT);
  assign last_bit  = shifting && (bitcnt == '0);
  assign din_ready = hold_ready;
  assign accept    = din_valid && hold_ready;

  // Mid-frame words park in the buffer; on the last bit an empty buffer is bypassed.
  assign hold_wr   = accept && shifting && (!last_bit || hold_full);
  assign hold_rd   = last_bit && hold_full;
  assign load_en   = (!shifting && accept) || (last_bit && (hold_full || accept));
  assign load_word = hold_rd ? hold_data : din;

  piso_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk_out (clk_out),
    .reset   (reset),
    .wr_en   (hold_wr),
    .wr_data (din),
    .rd_en   (hold_rd),
    .data    (hold_data),
    .full    (hold_full),
    .ready   (hold_ready)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load_en) begin
      state  <= ST_SHIFT;
      shreg  <= load_word;
      bitcnt <= CNT_TOP;
    end else if (last_bit) begin
      state  <= ST_IDLE;
    end else if (shifting) begin
      shreg  <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
      bitcnt <= bitcnt - CNT_W'(1);
    end
  end

  assign data_bit = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

`ifdef PISO_PARITY_EN
  logic parity_q;

  // Parity is captured with the word so the shift register can drain freely.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load_en) begin
      parity_q <= ^load_word;
    end
  end

  assign ser_bit = (bitcnt == '0) ? parity_q : data_bit;
`else
  assign ser_bit = data_bit;
`endif

  assign dout       = shifting ? ser_bit : IDLE_LEVEL;
  assign dout_valid = shifting;
  assign dout_first = shifting && (bitcnt == CNT_TOP);
  assign dout_last  = last_bit;
  assign busy       = shifting || hold_full;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Bench for piso_stream_serializer: three configurations checked against a bit-queue model.
`timescale 1ns/1ps
module tb_piso_stream_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NI = 3;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic        clk_out = 1'b0;
  logic        reset;
  logic [31:0] din        [NI];
  logic        din_valid  [NI];
  logic        din_ready  [NI];
  logic        dout       [NI];
  logic        dout_valid [NI];
  logic        dout_first [NI];
  logic        dout_last  [NI];
  logic        busy       [NI];

  int checks = 0;
  int errors = 0;

  exp_t        mq    [NI][$];
  logic [31:0] src_q [NI][$];
  bit          accepted [NI];
  bit          gaps = 1'b0;

  always #5 clk_out = ~clk_out;

  piso_stream_serializer #(.DATA_W(32), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w32 (
    .clk_out(clk_out), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
    .dout_first(dout_first[0]), .dout_last(dout_last[0]), .busy(busy[0]));

  piso_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_l8 (
    .clk_out(clk_out), .reset(reset), .din(din[1][7:0]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
    .dout_first(dout_first[1]), .dout_last(dout_last[1]), .busy(busy[1]));

  piso_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m8 (
    .clk_out(clk_out), .reset(reset), .din(din[2][7:0]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
    .dout_first(dout_first[2]), .dout_last(dout_last[2]), .busy(busy[2]));

  // ---------------- reference model: a queue of pending frame bits ----------------
  function automatic int width_of(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic bit msb_of(int i);
    return (i != 1);
  endfunction

  function automatic logic idle_of(int i);
    return (i == 1);
  endfunction

  function automatic int frame_len(int i);
    return width_of(i) + PAR;
  endfunction

  // Room for a new word unless two whole frames are already pending.
  function automatic bit m_ready(int i);
    int n = 0;
    for (int k = 0; k < mq[i].size(); k++) if (mq[i][k].last) n++;
    return n < 2;
  endfunction

  task automatic push_frame(int i, logic [31:0] w);
    int   n = width_of(i);
    logic p = 1'b0;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.b     = msb_of(i) ? w[n-1-k] : w[k];
      e.first = (k == 0);
      e.last  = (PAR == 0) && (k == n - 1);
      mq[i].push_back(e);
      p = p ^ w[k];
    end
    if (PAR != 0) begin
      e.b = p; e.first = 1'b0; e.last = 1'b1;
      mq[i].push_back(e);
    end
  endtask

  always @(posedge clk_out) begin : model_p
    bit acc;
    for (int i = 0; i < NI; i++) begin
      acc = !reset && din_valid[i] && m_ready(i);
      accepted[i] = acc;
      if (reset) begin
        mq[i].delete();
      end else begin
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        if (acc) push_frame(i, din[i]);
      end
    end
  end

  // {dout, dout_valid, dout_first, dout_last, busy, din_ready}
  function automatic logic [5:0] exp_vec(int i);
    if (mq[i].size() == 0) return {idle_of(i), 5'b00001};
    return {mq[i][0].b, 1'b1, mq[i][0].first, mq[i][0].last, 1'b1, m_ready(i)};
  endfunction

  function automatic logic [5:0] dut_vec(int i);
    return {dout[i], dout_valid[i], dout_first[i], dout_last[i], busy[i], din_ready[i]};
  endfunction

  // Source side: present queued words, hold them stable until accepted.
  task automatic drive_src();
    for (int i = 0; i < NI; i++) begin
      if (din_valid[i] && accepted[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        din_valid[i] = 1'b0;
      end
      if (!din_valid[i]) begin
        if (src_q[i].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
          din[i]       = src_q[i][0];
          din_valid[i] = 1'b1;
        end else begin
          din[i] = $urandom;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      din[i] = $urandom; din_valid[i] = 1'b1;
    end
    repeat (2) @(negedge clk_out);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (din_ready[i] !== 1'b1 || busy[i] !== 1'b0 || dout_valid[i] !== 1'b0 ||
          dout_first[i] !== 1'b0 || dout_last[i] !== 1'b0 || dout[i] !== idle_of(i)) begin
        errors++;
        $display("FAIL reset_state inst=%0d got=%b exp=%b", i, dut_vec(i), {idle_of(i), 5'b00001});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
    repeat (2) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL reset_release inst=%0d got=%b exp=%b", i, dut_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  // Runs a single word on instance inst and returns the first nbits shown plus framing stats.
  task automatic run_single(input string tag, input int inst, input logic [31:0] w, input int nbits,
                            output logic [31:0] seq, output int nvalid, output int nfirst,
                            output int first_at, output int last_at);
    seq = '0; nvalid = 0; nfirst = 0; first_at = -1; last_at = -1;
    gaps = 1'b0;
    src_q[inst].push_back(w);
    for (int c = 0; c < frame_len(inst) + 5; c++) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL %s cyc=%0d inst=%0d got=%b exp=%b", tag, c, i, dut_vec(i), exp_vec(i));
        end
      end
      if (dout_valid[inst]) begin
        nvalid++;
        if (nvalid <= nbits) seq = {seq[30:0], dout[inst]};
        if (dout_first[inst]) begin nfirst++; first_at = nvalid; end
        if (dout_last[inst]) last_at = nvalid;
      end
      drive_src();
    end
  endtask

  task automatic test_single_msb();
    logic [31:0] seq;
    int nv, nf, fa, la;
    run_single("single_msb", 0, 32'hA5A5_0F0F, 8, seq, nv, nf, fa, la);
    checks++;
    if (seq[7:0] !== 8'hA5) begin
      errors++; $display("FAIL single_msb_bits got=%b exp=%b", seq[7:0], 8'hA5);
    end
    checks++;
    if (nv !== 32 + PAR || nf !== 1 || fa !== 1 || la !== 32 + PAR) begin
      errors++;
      $display("FAIL single_msb_frame got nvalid=%0d nfirst=%0d first_at=%0d last_at=%0d exp %0d/1/1/%0d",
               nv, nf, fa, la, 32 + PAR, 32 + PAR);
    end
    checks++;
    if (busy[0] !== 1'b0 || dout_valid[0] !== 1'b0) begin
      errors++; $display("FAIL single_msb_idle got busy=%b valid=%b exp 0/0", busy[0], dout_valid[0]);
    end
  endtask

  task automatic test_lsb8();
    logic [31:0] seq;
    int nv, nf, fa, la;
    run_single("lsb8", 1, 32'h0000_0001, 8, seq, nv, nf, fa, la);
    checks++;
    if (seq[7:0] !== 8'b1000_0000 || nv !== 8 + PAR || la !== 8 + PAR) begin
      errors++;
      $display("FAIL lsb8 got bits=%b nvalid=%0d last_at=%0d exp bits=10000000 nvalid=%0d last_at=%0d",
               seq[7:0], nv, la, 8 + PAR, 8 + PAR);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, max_run = 0, nvalid = 0;
    bit saw_low = 1'b0;
    int fpos[$];
    int fl = 32 + PAR;
    gaps = 1'b0;
    src_q[0].push_back(32'h8000_0001);
    src_q[0].push_back(32'hFFFF_FFFF);
    src_q[0].push_back(32'h0000_0000);
    for (int c = 0; c < 3 * fl + 8; c++) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL back_to_back cyc=%0d inst=%0d got=%b exp=%b", c, i, dut_vec(i), exp_vec(i));
        end
      end
      if (dout_valid[0]) begin
        nvalid++; run++;
        if (run > max_run) max_run = run;
        if (dout_first[0]) fpos.push_back(nvalid);
      end else begin
        run = 0;
      end
      if (din_valid[0] && !din_ready[0]) saw_low = 1'b1;
      drive_src();
    end
    checks++;
    if (max_run !== 3 * fl || !saw_low) begin
      errors++;
      $display("FAIL back_to_back_stream got run=%0d ready_low=%0d exp run=%0d ready_low=1", max_run, saw_low, 3 * fl);
    end
    checks++;
    if (fpos.size() !== 3) begin
      errors++; $display("FAIL back_to_back_firsts got count=%0d exp 3", fpos.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (fpos[k] !== k * fl + 1) begin
          errors++; $display("FAIL back_to_back_first%0d got=%0d exp=%0d", k, fpos[k], k * fl + 1);
        end
      end
    end
  endtask

  task automatic test_bypass();
    int phase = 0;
    for (int c = 0; c < 40 && phase < 3; c++) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL bypass cyc=%0d inst=%0d got=%b exp=%b", c, i, dut_vec(i), exp_vec(i));
        end
      end
      case (phase)
        0: begin din[2] = 32'h0000_0000; din_valid[2] = 1'b1; phase = 1; end
        1: begin
          din_valid[2] = 1'b0;
          if (mq[2].size() == 1) begin
            din[2] = 32'h0000_00A6; din_valid[2] = 1'b1; phase = 2;
          end
        end
        default: begin
          din_valid[2] = 1'b0;
          checks++;
          if (dout_first[2] !== 1'b1 || dout[2] !== 1'b1 || dout_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_load got first=%b dout=%b valid=%b exp 1/1/1", dout_first[2], dout[2], dout_valid[2]);
          end
          phase = 3;
        end
      endcase
    end
    checks++;
    if (phase != 3) begin
      errors++; $display("FAIL bypass_timeout got phase=%0d exp 3", phase);
    end
    repeat (12) @(negedge clk_out);
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    bit hit = 1'b0;
    gaps = 1'b0;
    src_q[0].push_back($urandom | 32'h1);
    src_q[0].push_back($urandom | 32'h1);
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL reset_mid cyc=%0d inst=%0d got=%b exp=%b", c, i, dut_vec(i), exp_vec(i));
        end
      end
      if (dout_valid[0]) nvalid++;
      if (nvalid == 10) begin
        hit = 1'b1;
        checks++;
        if (busy[0] !== 1'b1 || din_ready[0] !== 1'b0) begin
          errors++; $display("FAIL reset_mid_hold got busy=%b ready=%b exp 1/0", busy[0], din_ready[0]);
        end
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin src_q[i].delete(); din_valid[i] = 1'b0; end
      end else begin
        drive_src();
      end
    end
    @(negedge clk_out);
    reset = 1'b0;
    checks++;
    if (!hit || dout[0] !== 1'b0 || dout_valid[0] !== 1'b0 || busy[0] !== 1'b0 || din_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after got hit=%0d dout=%b valid=%b busy=%b ready=%b exp 1/0/0/0/1",
               hit, dout[0], dout_valid[0], busy[0], din_ready[0]);
    end
    nvalid = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk_out);
      if (dout_valid[0]) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin
      errors++; $display("FAIL reset_mid_residue got bits=%0d exp 0", nvalid);
    end
  endtask

  task automatic test_random();
    gaps = 1'b1;
    for (int i = 0; i < NI; i++) repeat (6) src_q[i].push_back($urandom);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_out);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random cyc=%0d inst=%0d got=%b exp=%b", c, i, dut_vec(i), exp_vec(i));
        end
      end
      drive_src();
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (src_q[i].size() !== 0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL random_drain inst=%0d got left=%0d busy=%b exp 0/0", i, src_q[i].size(), busy[i]);
      end
    end
    gaps = 1'b0;
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [31:0] seq;
    int nv, nf, fa, la;
    run_single("parity", 2, 32'h0000_0007, 9, seq, nv, nf, fa, la);
    checks++;
    if (seq[8:0] !== 9'b0_0000_1111 || nv !== 9 || la !== 9) begin
      errors++;
      $display("FAIL parity got bits=%b nvalid=%0d last_at=%0d exp bits=000001111 nvalid=9 last_at=9",
               seq[8:0], nv, la);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      din[i] = '0; din_valid[i] = 1'b0; accepted[i] = 1'b0;
    end
    test_reset();
    test_single_msb();
    test_lsb8();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_random();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
